clkdiv_cfg_arbiter: RTL and testbench
=====================================

# clkdiv_cfg_arbiter

Programmable synchronous clock divider with an integrated ratio-update controller shared by two configuration requesters. Two agents submit divide ratios over valid/ready handshakes. A round-robin arbiter grants one request at a time. The controller holds the granted ratio and applies it only at a divider wrap boundary, so `clk_out` never produces a runt pulse. The block sits beside the fixed mod-N dividers and replaces them wherever the division ratio must change at run time.

## Interface
Parameters:
- `CNT_W`, default 4: width of the counter and of the ratio fields. Legal ratios are 2..2^CNT_W-1.
- `DEFAULT_DIV`, default 6: ratio loaded at reset. Must lie in 2..2^CNT_W-1.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req0_valid`, input, 1: requester 0 has a ratio to submit.
- `req0_div`, input, CNT_W: requester 0 ratio.
- `req0_ready`, output, 1: requester 0 handshake completes this cycle.
- `req1_valid`, input, 1: requester 1 has a ratio to submit.
- `req1_div`, input, CNT_W: requester 1 ratio.
- `req1_ready`, output, 1: requester 1 handshake completes this cycle.
- `clk_out`, output, 1: divided clock, registered.
- `tick`, output, 1: one-cycle pulse in the first cycle of each period (cnt==0).
- `cur_div`, output, CNT_W: ratio currently in effect.
- `busy`, output, 1: an accepted ratio is pending application.
- `err`, output, 1: one-cycle pulse after an illegal ratio (<2) is accepted.

## Operation
- Counter `cnt` runs 0..cur_div-1, then wraps to 0.
- `clk_out` is registered. At each edge, `clk_out <= (cnt_next >= div_next>>1)`.
  - div=6: high for cnt 3..5.
  - div=5: high for cnt 2..4.
  - div=2: toggles every cycle.
- FSM states:
  - IDLE → PEND: on a handshake with a legal ratio. The ratio is stored in `pend_div`.
  - IDLE → IDLE: on a handshake with an illegal ratio. `err` pulses the following cycle; nothing else changes.
  - PEND → IDLE: at the edge where cnt==cur_div-1. At that same edge: cur_div<=pend_div, cnt<=0, tick<=1.
- Ready rules:
  - `reqX_ready` is combinational and high only in IDLE, for the granted requester.
  - The grant depends on the valids only; it never depends on ready.
  - At most one ready is high per cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that was not granted last is granted.
  - `last_grant` updates on every completed handshake, legal or illegal.
- Requesters hold valid and data until ready. Deasserting valid before ready is legal, and no handshake occurs.
- `busy` = (state==PEND), registered.
- Width rules:
  - All comparisons are unsigned, CNT_W bits.
  - `div>>1` floors.
  - No ratio of 0 or 1 ever reaches cur_div.

## Timing
- Reset values: cnt=0, cur_div=DEFAULT_DIV, clk_out=0, tick=0, err=0, busy=0, state=IDLE, last_grant=1, so requester 0 wins the first tie.
- First `tick` occurs DEFAULT_DIV cycles after reset release.
- Accepted at edge A: busy=1 from A. The new ratio takes effect at the first wrap edge strictly after A. Acceptance at the wrap edge itself does not apply the ratio until the next wrap.
- The old period always completes. The first new period starts with tick=1 and cnt=0.
- New requests are stalled (ready=0) while busy.
- An illegal request completes its handshake with no stall. `err`=1 for exactly the one following cycle.
- Reset asserted mid-period or during PEND:
  - All state returns immediately to reset values.
  - The pending ratio is discarded.
  - No further pulse on `clk_out`.

## Structure
- Package `clkdiv_pkg` holds:
  - the state enum (IDLE, PEND);
  - `CNT_W` default;
  - `MIN_DIV`=2;
  - the requester-index constants.
- Sub-module `rr_arb2` is a two-way round-robin arbiter.
  - Inputs: valids, `last_grant`.
  - Outputs: one-hot grant.
  - Purely combinational. The `last_grant` register stays in the top level.

## Test plan
- Reset release with no requests: `clk_out` period 6, high for 3 cycles; tick every 6 cycles, first at cycle 6.
- req0 submits 4 mid-period: ready same cycle; busy until wrap; current 6-cycle period completes; then period 4 with 2 high; cur_div=4.
- req0=3 and req1=9 valid together from IDLE after reset: req0 granted first, applied at next wrap; req1 waits with ready=0 while busy; req1 granted in the IDLE cycle after apply, applied at the following wrap.
- req1 submits 1: handshake completes, err pulses one cycle, cur_div unchanged, busy stays 0.
- Request accepted on the wrap edge (cnt==cur_div-1): ratio not applied until the following wrap.
- rst asserted while PEND with pend_div=2: outputs return to reset values asynchronously; after release, period is DEFAULT_DIV.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg
// Shared definitions for the run-time programmable clock divider and its
// two-requester ratio-update controller.
//   - state_t       : controller state (IDLE accepts requests, PEND holds one)
//   - DEF_CNT_W     : default counter / ratio width
//   - MIN_DIV       : smallest ratio that can be applied
//   - REQ0 / REQ1   : bit positions of each requester in valid/grant vectors
package clkdiv_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int MIN_DIV   = 2;
  localparam int NUM_REQ   = 2;
  localparam int REQ0      = 0;
  localparam int REQ1      = 1;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Purely combinational two-way round-robin arbiter.
// Ports:
//   valid      : request vector, bit REQ0 / REQ1
//   last_grant : index of the requester that completed the previous handshake
//   grant      : one-hot grant (all zero when nothing is valid)
// The grant depends only on the valids and the history bit, never on any
// ready, so a requester can rely on it while waiting.
module rr_arb2
  import clkdiv_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // On a tie the requester that did not win last time is served; with a
  // single requester there is nothing to arbitrate.
  always_comb begin
    grant = '0;
    if (valid[REQ0] && valid[REQ1]) begin
      if (last_grant) begin
        grant[REQ0] = 1'b1;
      end else begin
        grant[REQ1] = 1'b1;
      end
    end else if (valid[REQ0]) begin
      grant[REQ0] = 1'b1;
    end else if (valid[REQ1]) begin
      grant[REQ1] = 1'b1;
    end
  end

endmodule

// File: rtl/clkdiv_cfg_arbiter.sv
// clkdiv_cfg_arbiter
// Programmable synchronous clock divider whose ratio can be changed at run
// time by two requesters. A new ratio is held pending and only applied at a
// divider wrap, so clk_out never produces a runt pulse.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN_valid / reqN_div         : requester N offers a ratio
//   reqN_ready                    : requester N handshake completes this cycle
//   clk_out                       : registered divided clock
//   tick                          : pulse in the first cycle of each period
//   cur_div                       : ratio currently in effect
//   busy                          : an accepted ratio waits for the next wrap
//   err                           : one-cycle pulse after an illegal ratio
module clkdiv_cfg_arbiter
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [CNT_W-1:0] req0_div,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [CNT_W-1:0] req1_div,
  output logic             req1_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEFAULT_DIV_W = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV_W     = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE_W         = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cur_div_q, cur_div_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               err_q, err_d;
  logic               last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] grant;
  logic               idle;
  logic               hs_any;
  logic [CNT_W-1:0]   hs_div;
  logic               hs_legal;
  logic               wrap;

  assign valid_vec = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid      (valid_vec),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Requests are only served while no ratio is pending; a grant while
  // PEND is ignored so the pending ratio cannot be overwritten.
  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & grant[REQ0];
  assign req1_ready = idle & grant[REQ1];
  assign hs_any     = req0_ready | req1_ready;
  assign hs_div     = grant[REQ1] ? req1_div : req0_div;
  assign hs_legal   = (hs_div >= MIN_DIV_W);

  // cnt never exceeds cur_div-1 because the ratio only changes when cnt
  // restarts at zero.
  assign wrap = (cnt_q == (cur_div_q - ONE_W));

  // Controller: accept one ratio while IDLE, then hold it until the end of
  // the period that is running. An illegal ratio still completes the
  // handshake and moves the round-robin pointer, but only raises err.
  always_comb begin
    state_d      = state_q;
    pend_div_d   = pend_div_q;
    cur_div_d    = cur_div_q;
    last_grant_d = last_grant_q;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs_any) begin
          last_grant_d = grant[REQ1];
          if (hs_legal) begin
            pend_div_d = hs_div;
            state_d    = PEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          cur_div_d = pend_div_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Divider datapath. clk_out and tick are computed from the values the
  // counter and ratio will hold after this edge, so a ratio change at the
  // wrap is reflected in the very first cycle of the new period.
  always_comb begin
    cnt_d     = wrap ? '0 : (cnt_q + ONE_W);
    clk_out_d = (cnt_d >= (cur_div_d >> 1));
    tick_d    = (cnt_d == '0);
  end

  // All state registers share the asynchronous reset, which also discards
  // any pending ratio.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= DEFAULT_DIV_W;
      pend_div_q   <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign cur_div = cur_div_q;
  assign busy    = (state_q == PEND);
  assign err     = err_q;

endmodule

// File: tb/tb_clkdiv_cfg_arbiter.sv
// tb_clkdiv_cfg_arbiter
// Self-checking bench for clkdiv_cfg_arbiter: a behavioural model of the
// divider and ratio controller tracked per clock, a compare process on every
// falling edge, directed scenarios with hand-computed expectations, and a
// randomized phase with two independent requesters.
module tb_clkdiv_cfg_arbiter;

  localparam int CNT_W       = 4;
  localparam int DEFAULT_DIV = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid;
  logic [CNT_W-1:0] req0_div;
  logic             req0_ready;
  logic             req1_valid;
  logic [CNT_W-1:0] req1_div;
  logic             req1_ready;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             busy;
  logic             err;

  int  pass_cnt  = 0;
  int  check_cnt = 0;
  bit  cmp_en    = 1'b0;

  always #5 clk = ~clk;

  clkdiv_cfg_arbiter #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_div   (req0_div),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_div   (req1_div),
    .req1_ready (req1_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .cur_div    (cur_div),
    .busy       (busy),
    .err        (err)
  );

  // Behavioural model: position within the current period, ratio in force,
  // pending ratio (0 = none), who was served last, and the per-edge outputs.
  int m_pos, m_div, m_pend, m_last, m_clk, m_tick, m_err;
  bit m_hs0, m_hs1;

  // Which requester the model expects to be served right now (-1: nobody).
  function automatic int winner();
    if (m_pend != 0) return -1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance the model by one clock: the running period always finishes,
  // a pending ratio is swapped in at its end, and any handshake seen this
  // cycle is recorded.
  always @(posedge clk or posedge rst) begin : model
    int  w;
    int  d;
    bit  at_end;
    if (rst) begin
      m_pos = 0; m_div = DEFAULT_DIV; m_pend = 0; m_last = 1;
      m_clk = 0; m_tick = 0; m_err = 0; m_hs0 = 0; m_hs1 = 0;
    end else begin
      w      = winner();
      d      = (w == 1) ? int'(req1_div) : int'(req0_div);
      at_end = (m_pos == m_div - 1);
      m_hs0  = (w == 0);
      m_hs1  = (w == 1);
      if (at_end && m_pend != 0) begin
        m_div  = m_pend;
        m_pend = 0;
      end
      m_pos = at_end ? 0 : m_pos + 1;
      m_err = 0;
      if (w >= 0) begin
        m_last = w;
        if (d < 2) m_err = 1;
        else       m_pend = d;
      end
      m_tick = (m_pos == 0) ? 1 : 0;
      m_clk  = (m_pos >= m_div / 2) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic failTimeout(input string name);
    check_cnt++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin : compare
    int w;
    if (!rst && cmp_en) begin
      w = winner();
      checkOutput("clk_out", int'(clk_out), m_clk);
      checkOutput("tick", int'(tick), m_tick);
      checkOutput("cur_div", int'(cur_div), m_div);
      checkOutput("busy", int'(busy), (m_pend != 0) ? 1 : 0);
      checkOutput("err", int'(err), m_err);
      checkOutput("req0_ready", int'(req0_ready), (w == 0) ? 1 : 0);
      checkOutput("req1_ready", int'(req1_ready), (w == 1) ? 1 : 0);
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    waitCycle();
    rst = 1'b1;
    #1;
    checkOutput("rst_clk_out", int'(clk_out), 0);
    checkOutput("rst_tick", int'(tick), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_cur_div", int'(cur_div), DEFAULT_DIV);
    waitCycle();
    waitCycle();
    rst = 1'b0;
  endtask

  // Random requester behaviour for one cycle: drop valid after a completed
  // handshake or occasionally withdraw, otherwise hold; idle requesters
  // sometimes raise a new ratio (including illegal 0 and 1).
  task automatic applyStimulus();
    if (req0_valid && (m_hs0 || $urandom_range(0, 19) == 0)) req0_valid = 1'b0;
    if (req1_valid && (m_hs1 || $urandom_range(0, 19) == 0)) req1_valid = 1'b0;
    if (!req0_valid && $urandom_range(0, 3) == 0) begin
      req0_valid = 1'b1;
      req0_div   = CNT_W'($urandom_range(0, 15));
    end
    if (!req1_valid && $urandom_range(0, 3) == 0) begin
      req1_valid = 1'b1;
      req1_div   = CNT_W'($urandom_range(0, 15));
    end
  endtask

  initial begin : stim
    int n;
    int highs;
    int first_tick;
    bit done;

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_div = '0; req1_div = '0;
    cmp_en = 1'b1;

    // Reset release, no requests: period 6, high for 3, first tick at 6.
    doReset();
    highs = 0; first_tick = 0;
    for (int k = 1; k <= 6; k++) begin
      waitCycle();
      highs += int'(clk_out);
      if (tick && first_tick == 0) first_tick = k;
    end
    checkOutput("t1_first_tick", first_tick, 6);
    checkOutput("t1_high_cycles", highs, 3);

    // req0 submits 4 mid-period (cnt=2): 6-cycle period completes first.
    waitCycle(); waitCycle();
    req0_valid = 1'b1; req0_div = 4'd4;
    #1;
    checkOutput("t2_ready0_same_cycle", int'(req0_ready), 1);
    waitCycle();
    req0_valid = 1'b0;
    checkOutput("t2_busy_after_accept", int'(busy), 1);
    n = 0; done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      waitCycle(); n++;
      if (!busy) done = 1;
    end
    if (!done) failTimeout("t2_busy_clear");
    checkOutput("t2_busy_cycles", n, 3);
    checkOutput("t2_cur_div", int'(cur_div), 4);
    checkOutput("t2_tick_at_apply", int'(tick), 1);
    highs = 0; n = 0; done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      waitCycle(); n++;
      highs += int'(clk_out);
      if (tick) done = 1;
    end
    checkOutput("t2_new_period", n, 4);
    checkOutput("t2_new_high", highs, 2);

    // req1 submits illegal ratio 1: err pulse only, nothing else changes.
    req1_valid = 1'b1; req1_div = 4'd1;
    #1;
    checkOutput("t3_ready1", int'(req1_ready), 1);
    waitCycle();
    req1_valid = 1'b0;
    checkOutput("t3_err_pulse", int'(err), 1);
    checkOutput("t3_busy", int'(busy), 0);
    checkOutput("t3_cur_div", int'(cur_div), 4);
    waitCycle();
    checkOutput("t3_err_clear", int'(err), 0);

    // Acceptance on the wrap edge is not applied until the following wrap.
    done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      if (m_pos == 3) done = 1;
      else waitCycle();
    end
    if (!done) failTimeout("t4_align");
    req0_valid = 1'b1; req0_div = 4'd5;
    waitCycle();
    req0_valid = 1'b0;
    checkOutput("t4_busy", int'(busy), 1);
    checkOutput("t4_cur_div_at_accept", int'(cur_div), 4);
    waitCycle(); waitCycle(); waitCycle();
    checkOutput("t4_cur_div_before_wrap", int'(cur_div), 4);
    waitCycle();
    checkOutput("t4_cur_div_applied", int'(cur_div), 5);
    checkOutput("t4_tick_applied", int'(tick), 1);

    // Both valid after reset: req0 first, req1 waits and follows.
    doReset();
    req0_valid = 1'b1; req0_div = 4'd3;
    req1_valid = 1'b1; req1_div = 4'd9;
    #1;
    checkOutput("t5_ready0_tie", int'(req0_ready), 1);
    checkOutput("t5_ready1_tie", int'(req1_ready), 0);
    waitCycle();
    req0_valid = 1'b0;
    checkOutput("t5_ready1_stalled", int'(req1_ready), 0);
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      waitCycle();
      if (m_hs1) done = 1;
    end
    if (!done) failTimeout("t5_req1_grant");
    req1_valid = 1'b0;
    checkOutput("t5_cur_div_first", int'(cur_div), 3);
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      waitCycle();
      if (!busy) done = 1;
    end
    if (!done) failTimeout("t5_apply_second");
    checkOutput("t5_cur_div_second", int'(cur_div), 9);

    // Reset while PEND with ratio 2: discard it, restart at DEFAULT_DIV.
    req0_valid = 1'b1; req0_div = 4'd2;
    waitCycle();
    req0_valid = 1'b0;
    checkOutput("t6_busy_pend", int'(busy), 1);
    doReset();
    n = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      waitCycle(); n++;
      if (tick) done = 1;
    end
    checkOutput("t6_period_after_reset", n, DEFAULT_DIV);
    checkOutput("t6_cur_div", int'(cur_div), DEFAULT_DIV);

    // Randomized traffic from both requesters.
    for (int k = 0; k < 600; k++) begin
      applyStimulus();
      waitCycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitCycle(); waitCycle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
